version_string_streamer: RTL
============================

Name: version_string_streamer

Overview:
- Bus-master sequencer that sits directly downstream of the version_string peripheral.
- On a start pulse it requests the shared peripheral bus, then reads every version-string word in order at BaseAddress + k*Address_Wording.
- It unpacks each word into bytes, drops NUL padding, and streams the characters over a valid/ready byte interface toward the UART TX path.
- Used for the boot banner and for the console "version" command without CPU involvement.

Parameters:
- BaseAddress, 0, address of the version_string block on the bus.
- NumCharacters, 44, total characters held by the peripheral.
- CharsPerTransaction, 1, bytes carried per bus word; must satisfy CharsPerTransaction*8 <= data_width.
- address_width, 15, bus address width.
- data_width, 16, bus data width.
- Address_Wording, 1, address stride between consecutive words.
- AppendNewline, 1, 1 = emit 0x0D then 0x0A after the last character.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk_i).
- start_i  in  1  single-cycle request to stream the string.
- busy_o  out  1  high from accepted start until done_o.
- done_o  out  1  one-cycle pulse after the final byte is accepted.
- bus_req_o  out  1  bus request to the arbiter.
- bus_gnt_i  in  1  bus grant.
- address_o  out  address_width  bus address.
- rd_wr_o  out  1  0 = read; held at 1 (write, ignored by the peripheral) when not reading.
- data_i  in  data_width  registered read data from the peripheral.
- char_o  out  8  character byte.
- char_valid_o  out  1  char_o valid.
- char_ready_i  in  1  consumer accepts char_o.

Behaviour:
- Constants:
  - NumWords = ceil(NumCharacters / CharsPerTransaction).
  - Word k address = (BaseAddress + k*Address_Wording), truncated to address_width.
- Reset (reset_i = 0 at a rising edge) forces state IDLE and zeroes word/byte counters. All outputs:
  - busy_o = 0, done_o = 0, bus_req_o = 0, address_o = 0, rd_wr_o = 1, char_o = 0x00, char_valid_o = 0.
  - Reset mid-operation aborts immediately; no partial state survives.
- FSM states: IDLE, REQ, ADDR, CAPT, EMIT, NL_CR, NL_LF, DONE.
- IDLE:
  - start_i = 1 -> REQ, busy_o = 1, word index k = 0.
  - start_i is ignored in every other state.
- REQ: bus_req_o = 1, held through CAPT. On bus_gnt_i = 1 -> ADDR.
- ADDR:
  - Drive address_o = word k address, rd_wr_o = 0.
  - The peripheral registers data_o on this edge.
  - Next state CAPT.
- CAPT:
  - Hold the same address_o and rd_wr_o = 0.
  - Latch data_i into a word register at the end of the cycle, then go to EMIT with byte index b = 0.
  - Read latency is therefore exactly 2 cycles from ADDR entry.
- Grant loss: if bus_gnt_i = 0 during ADDR or CAPT, discard the cycle, return to REQ, and reissue the same k.
- bus_req_o drops on CAPT exit and re-asserts for the next word; the bus is released between words.
- EMIT:
  - Byte b = word[8*(CharsPerTransaction-1-b) +: 8], i.e. most significant byte first.
  - If the byte is 0x00 it is skipped in one cycle with no valid.
  - Otherwise char_valid_o = 1 and char_o is held stable until char_ready_i = 1. The transfer occurs on the cycle where valid & ready are both 1.
  - When the last byte of the word is consumed:
    - if k < NumWords-1: k++, go to REQ;
    - else if AppendNewline = 1: go to NL_CR;
    - else: go to DONE.
- Character cap: bytes with global character index >= NumCharacters (partial last word) are skipped as if NUL.
- NL_CR: emit 0x0D with the same valid/ready rule, then NL_LF. NL_LF: emit 0x0A, then DONE.
- DONE: done_o = 1 for one cycle, busy_o = 0, then IDLE.
- No combinational path from char_ready_i to address_o or bus_req_o. char_valid_o is registered.

Decomposition:
- Package version_stream_pkg holds:
  - the state enum vs_state_t;
  - localparam functions num_words() and word_addr();
  - constants CR = 8'h0D, LF = 8'h0A.
- Sub-module byte_unpacker (word register plus byte index mux plus NUL/cap skip logic) is natural. The top-level module keeps the FSM and the bus side.

Test Plan:
- data_width = 8, CharsPerTransaction = 1, peripheral model holding "V1.2" with 40 NUL pads, always-ready sink, grant tied to 1 -> stream is 0x56 0x31 0x2E 0x32 0x0D 0x0A; done_o pulses once; address_o sweeps 0..43.
- Same setup, char_ready_i low for 5 cycles on the second byte -> char_o stays 0x31 with valid high throughout; no byte is lost or duplicated.
- data_width = 16, CharsPerTransaction = 2, word 0 = 0x4142 -> bytes emitted as 0x41 then 0x42.
- Grant drops in CAPT of word 3 -> word 3 is re-read; its byte appears exactly once.
- reset_i = 0 for one cycle during EMIT -> next cycle all outputs at reset values; a new start_i then restarts from address BaseAddress.
- start_i pulsed while busy -> ignored; exactly one done_o pulse.

Source files
------------

// File: rtl/version_stream_pkg.sv
// Shared types and helpers for the version-string streaming sequencer.
package version_stream_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAddr,
        StCapt,
        StEmit,
        StNlCr,
        StNlLf,
        StDone
    } vs_state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    function automatic int unsigned num_words(input int unsigned num_chars,
                                              input int unsigned chars_per_word);
        return (num_chars + chars_per_word - 1) / chars_per_word;
    endfunction

    function automatic int unsigned word_addr(input int unsigned base,
                                              input int unsigned k,
                                              input int unsigned stride);
        return base + k * stride;
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Holds one captured bus word and walks its bytes MSB first, flagging NUL and
// past-the-end characters so the sequencer can skip them.
module byte_unpacker #(
    parameter int unsigned DataWidth           = 16,
    parameter int unsigned CharsPerTransaction = 1,
    parameter int unsigned NumCharacters       = 44,
    parameter int unsigned KWidth              = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 advance_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [KWidth-1:0]    word_idx_i,
    output logic [7:0]           byte_o,
    output logic                 skip_o,
    output logic                 last_o
);

    localparam int unsigned BWidth = (CharsPerTransaction > 1) ? $clog2(CharsPerTransaction) : 1;

    logic [DataWidth-1:0] word_q, word_d;
    logic [BWidth-1:0]    idx_q, idx_d;
    int unsigned          shamt;
    int unsigned          char_idx;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = data_i;
            idx_d  = '0;
        end else if (advance_i) begin
            idx_d = idx_q + BWidth'(1);
        end

        shamt    = 8 * (CharsPerTransaction - 1 - 32'(idx_q));
        byte_o   = 8'(word_q >> shamt);
        // Characters beyond NumCharacters live in the padded tail of the last word.
        char_idx = 32'(word_idx_i) * CharsPerTransaction + 32'(idx_q);
        skip_o   = (byte_o == 8'h00) || (char_idx >= NumCharacters);
        last_o   = (idx_q == BWidth'(CharsPerTransaction - 1));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/version_string_streamer.sv
// Bus-master sequencer: reads the version-string peripheral word by word and
// streams its non-NUL characters (plus optional CR/LF) over a valid/ready byte port.
module version_string_streamer
    import version_stream_pkg::*;
#(
    parameter int unsigned BaseAddress         = 0,
    parameter int unsigned NumCharacters       = 44,
    parameter int unsigned CharsPerTransaction = 1,
    parameter int unsigned address_width       = 15,
    parameter int unsigned data_width          = 16,
    parameter int unsigned Address_Wording     = 1,
    parameter int unsigned AppendNewline       = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     bus_req_o,
    input  logic                     bus_gnt_i,
    output logic [address_width-1:0] address_o,
    output logic                     rd_wr_o,
    input  logic [data_width-1:0]    data_i,
    output logic [7:0]               char_o,
    output logic                     char_valid_o,
    input  logic                     char_ready_i
);

    localparam int unsigned NumWords = num_words(NumCharacters, CharsPerTransaction);
    localparam int unsigned KWidth   = (NumWords > 1) ? $clog2(NumWords) : 1;

    vs_state_t                state_q, state_d;
    logic [KWidth-1:0]        k_q, k_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     bus_req_q, bus_req_d;
    logic [address_width-1:0] address_q, address_d;
    logic                     rd_wr_q, rd_wr_d;
    logic [7:0]               char_q, char_d;
    logic                     char_valid_q, char_valid_d;

    logic       load, advance, byte_done;
    logic [7:0] unpacked_byte;
    logic       byte_skip, byte_last;

    byte_unpacker #(
        .DataWidth          (data_width),
        .CharsPerTransaction(CharsPerTransaction),
        .NumCharacters      (NumCharacters),
        .KWidth             (KWidth)
    ) u_unpacker (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (load),
        .advance_i (advance),
        .data_i    (data_i),
        .word_idx_i(k_q),
        .byte_o    (unpacked_byte),
        .skip_o    (byte_skip),
        .last_o    (byte_last)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        char_d       = char_q;
        char_valid_d = char_valid_q;
        load         = 1'b0;
        advance      = 1'b0;
        byte_done    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StReq;
                    k_d     = '0;
                end
            end
            StReq:  if (bus_gnt_i) state_d = StAddr;
            StAddr: state_d = bus_gnt_i ? StCapt : StReq;
            StCapt: begin
                if (bus_gnt_i) begin
                    load    = 1'b1;
                    state_d = StEmit;
                end else begin
                    state_d = StReq;
                end
            end
            StEmit: begin
                // A byte is first loaded into the output register, then held until taken.
                if (char_valid_q) begin
                    if (char_ready_i) begin
                        char_valid_d = 1'b0;
                        byte_done    = 1'b1;
                    end
                end else if (byte_skip) begin
                    byte_done = 1'b1;
                end else begin
                    char_valid_d = 1'b1;
                    char_d       = unpacked_byte;
                end
                if (byte_done) begin
                    if (!byte_last) begin
                        advance = 1'b1;
                    end else if (k_q != KWidth'(NumWords - 1)) begin
                        k_d     = k_q + KWidth'(1);
                        state_d = StReq;
                    end else begin
                        state_d = (AppendNewline != 0) ? StNlCr : StDone;
                    end
                end
            end
            StNlCr: begin
                if (char_valid_q) begin
                    if (char_ready_i) begin
                        char_valid_d = 1'b0;
                        state_d      = StNlLf;
                    end
                end else begin
                    char_valid_d = 1'b1;
                    char_d       = CR;
                end
            end
            StNlLf: begin
                if (char_valid_q) begin
                    if (char_ready_i) begin
                        char_valid_d = 1'b0;
                        state_d      = StDone;
                    end
                end else begin
                    char_valid_d = 1'b1;
                    char_d       = LF;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus-side outputs follow the next state so they are registered with it.
        busy_d    = !(state_d == StIdle || state_d == StDone);
        done_d    = (state_d == StDone);
        bus_req_d = (state_d == StReq) || (state_d == StAddr) || (state_d == StCapt);
        rd_wr_d   = !((state_d == StAddr) || (state_d == StCapt));
        address_d = address_q;
        if (state_d == StAddr) begin
            address_d = address_width'(word_addr(BaseAddress, 32'(k_d), Address_Wording));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= StIdle;
            k_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            address_q    <= '0;
            rd_wr_q      <= 1'b1;
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bus_req_q    <= bus_req_d;
            address_q    <= address_d;
            rd_wr_q      <= rd_wr_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign bus_req_o    = bus_req_q;
    assign address_o    = address_q;
    assign rd_wr_o      = rd_wr_q;
    assign char_o       = char_q;
    assign char_valid_o = char_valid_q;

endmodule
